tv80_alu16_seq: RTL and testbench

- Multi-cycle 16-bit arithmetic sequencer that acts as the initiator on the 8-bit ALU port set (op, operand buses, flag in/out, Arith16/Z16).
- Executes each 16-bit operation as two byte passes through the 8-bit ALU: low byte first, then high byte with the carry chained.
- Used for ADD HL,rr / ADC HL,rr / SBC HL,rr and ADD SP,e8. Sits between the core sequencer and the 8-bit ALU instance.

---
 rtl/tv80_alu16_seq.sv | 135 +++++++++++++
 tb/tb_tv80_alu16_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tv80_alu16_seq.sv
// rtl/tv80_alu16_seq.sv - two-pass 16-bit add/adc/sbc sequencer driving an 8-bit TV80 ALU (optional TV80_ALU16_BACK2BACK_EN)
module tv80_alu16_seq #(
  parameter logic [3:0] ALU_ADD = 4'b0000,
  parameter logic [3:0] ALU_ADC = 4'b0001,
  parameter logic [3:0] ALU_SBC = 4'b0011
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic [7:0]  f_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [7:0]  f_out,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_busa,
  output logic [7:0]  alu_busb,
  output logic [7:0]  alu_f_in,
  output logic        alu_arith16,
  output logic        alu_z16,
  input  logic [7:0]  alu_q,
  input  logic [7:0]  alu_f_out
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  localparam logic [1:0] OP_ADD16  = 2'b00;
  localparam logic [1:0] OP_ADC16  = 2'b01;
  localparam logic [1:0] OP_SBC16  = 2'b10;
  localparam logic [1:0] OP_ADDSPE = 2'b11;

  // Z (bit 6) and N (bit 1) are forced low for ADD SP,e8
  localparam logic [7:0] ADDSPE_FMASK = 8'hBD;

  state_t      state, state_nxt;
  logic [1:0]  op_r;
  logic [15:0] opa_r;
  logic [15:0] opb_r;
  logic [7:0]  fin_r;
  logic [7:0]  flo;
  logic        accept;

`ifdef TV80_ALU16_BACK2BACK_EN
  assign accept = start && ((state == S_IDLE) || (state == S_DONE));
`else
  assign accept = start && (state == S_IDLE);
`endif

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and byte/flag routing towards the 8-bit ALU
  always_comb begin
    state_nxt   = state;
    alu_op      = 4'b0000;
    alu_busa    = 8'h00;
    alu_busb    = 8'h00;
    alu_f_in    = 8'h00;
    alu_arith16 = 1'b0;
    alu_z16     = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_LO;
      end
      S_LO: begin
        alu_busa    = opa_r[7:0];
        alu_busb    = opb_r[7:0];
        alu_f_in    = fin_r;
        alu_arith16 = (op_r == OP_ADD16);
        case (op_r)
          OP_ADC16: alu_op = ALU_ADC;
          OP_SBC16: alu_op = ALU_SBC;
          default:  alu_op = ALU_ADD;
        endcase
        state_nxt = S_HI;
      end
      S_HI: begin
        alu_busa    = opa_r[15:8];
        alu_busb    = (op_r == OP_ADDSPE) ? {8{opb_r[7]}} : opb_r[15:8];
        alu_op      = (op_r == OP_SBC16) ? ALU_SBC : ALU_ADC;
        alu_f_in    = flo;
        alu_arith16 = (op_r == OP_ADD16);
        // Z from the high pass must reflect both bytes for ADC/SBC
        alu_z16     = (op_r == OP_ADC16) || (op_r == OP_SBC16);
        state_nxt   = S_DONE;
      end
      S_DONE: begin
        state_nxt = accept ? S_LO : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latches, low-pass flag capture and result/flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_r   <= 2'b00;
      opa_r  <= 16'h0000;
      opb_r  <= 16'h0000;
      fin_r  <= 8'h00;
      flo    <= 8'h00;
      result <= 16'h0000;
      f_out  <= 8'h00;
    end else begin
      if (accept) begin
        op_r  <= op;
        opa_r <= opa;
        opb_r <= opb;
        fin_r <= f_in;
      end
      if (state == S_LO) begin
        result[7:0] <= alu_q;
        flo         <= alu_f_out;
      end
      if (state == S_HI) begin
        result[15:8] <= alu_q;
        // ADD SP,e8 reports H and C from the low byte only
        f_out <= (op_r == OP_ADDSPE) ? (flo & ADDSPE_FMASK) : alu_f_out;
      end
    end
  end

endmodule

// File: tb/tb_tv80_alu16_seq.sv
// tb/tb_tv80_alu16_seq.sv - directed bench for tv80_alu16_seq with a behavioural 8-bit ALU
module tb_tv80_alu16_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] opa;
  logic [15:0] opb;
  logic [7:0]  f_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [7:0]  f_out;
  logic [3:0]  alu_op;
  logic [7:0]  alu_busa;
  logic [7:0]  alu_busb;
  logic [7:0]  alu_f_in;
  logic        alu_arith16;
  logic        alu_z16;
  logic [7:0]  alu_q;
  logic [7:0]  alu_f_out;

  int n_checks = 0;
  int n_fail   = 0;

  tv80_alu16_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .f_in(f_in), .busy(busy), .done(done), .result(result), .f_out(f_out),
    .alu_op(alu_op), .alu_busa(alu_busa), .alu_busb(alu_busb), .alu_f_in(alu_f_in),
    .alu_arith16(alu_arith16), .alu_z16(alu_z16), .alu_q(alu_q), .alu_f_out(alu_f_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural TV80 ALU for ADD/ADC/SUB/SBC
  logic       m_sub;
  logic       m_cin;
  logic [7:0] m_b;
  logic [4:0] m_s4;
  logic [7:0] m_s7;
  logic [8:0] m_s8;
  logic [7:0] m_f;
  always_comb begin
    m_sub = alu_op[1];
    m_cin = m_sub ^ (~alu_op[2] & alu_op[0] & alu_f_in[0]);
    m_b   = alu_busb ^ {8{m_sub}};
    m_s4  = {1'b0, alu_busa[3:0]} + {1'b0, m_b[3:0]} + {4'b0, m_cin};
    m_s7  = {1'b0, alu_busa[6:0]} + {1'b0, m_b[6:0]} + {7'b0, m_cin};
    m_s8  = {1'b0, alu_busa} + {1'b0, m_b} + {8'b0, m_cin};
    m_f    = alu_f_in;
    m_f[0] = m_s8[8] ^ m_sub;
    m_f[1] = m_sub;
    m_f[2] = m_s8[8] ^ m_s7[7];
    m_f[3] = m_s8[3];
    m_f[4] = m_s4[4] ^ m_sub;
    m_f[5] = m_s8[5];
    m_f[6] = (m_s8[7:0] == 8'h00) ? (alu_z16 ? alu_f_in[6] : 1'b1) : 1'b0;
    m_f[7] = m_s8[7];
    if (alu_arith16) begin
      m_f[7] = alu_f_in[7];
      m_f[6] = alu_f_in[6];
      m_f[2] = alu_f_in[2];
    end
  end
  assign alu_q     = m_s8[7:0];
  assign alu_f_out = m_f;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [7:0] f,
                        input logic [15:0] er, input logic [7:0] ef);
    int lat;
    @(negedge clk);
    op = o; opa = a; opb = b; f_in = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 32'd3);
    check({tag, "_res"}, {16'b0, result}, {16'b0, er});
    check({tag, "_f"}, {24'b0, f_out}, {24'b0, ef});
    @(negedge clk);
    check({tag, "_done1"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int cnt;
    int gap;
    reset_n = 1'b0; start = 1'b0; op = 2'b00; opa = 16'h1234; opb = 16'h5678; f_in = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_res", {16'b0, result}, 32'd0);
    check("rst_f", {24'b0, f_out}, 32'd0);
    check("rst_alu", {alu_op, alu_busa, alu_busb, alu_f_in, alu_arith16, alu_z16, 2'b0}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_alu", {alu_op, alu_busa, alu_busb, alu_f_in, alu_arith16, alu_z16, 2'b0}, 32'd0);

    run_op("add16", 2'b00, 16'h0FFF, 16'h0001, 8'hC4, 16'h1000, 8'hD4);
    run_op("adc16", 2'b01, 16'hFFFF, 16'h0000, 8'h01, 16'h0000, 8'h51);
    run_op("adc16_z16", 2'b01, 16'h0101, 16'hFF00, 8'h00, 16'h0001, 8'h11);
    run_op("sbc16", 2'b10, 16'h8000, 16'h0001, 8'h00, 16'h7FFF, 8'h3E);
    run_op("addspe", 2'b11, 16'hFFF8, 16'h0008, 8'hFF, 16'h0000, 8'h11);
    run_op("addspe_neg", 2'b11, 16'h1000, 16'h00FF, 8'h00, 16'h0FFF, 8'hA8);

    // start held through an operation while opa changes underneath
    @(negedge clk);
    op = 2'b00; opa = 16'h0FFF; opb = 16'h0001; f_in = 8'hC4; start = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) cnt++;
      if (i == 2) start = 1'b0;
      opa = 16'hAAAA;
    end
    check("hold_cnt", cnt, 32'd1);
    check("hold_res", {16'b0, result}, 32'h1000);
    check("hold_f", {24'b0, f_out}, 32'hD4);
    check("hold_busy", {31'b0, busy}, 32'd0);

    // back-to-back: new start presented during DONE
    @(negedge clk);
    op = 2'b00; opa = 16'h1234; opb = 16'h1111; f_in = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    while (!done && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check("b2b_first_res", {16'b0, result}, 32'h2345);
    check("b2b_first_f", {24'b0, f_out}, 32'h20);
    op = 2'b10; opa = 16'h0000; opb = 16'h0001; f_in = 8'h00; start = 1'b1;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
      if (gap == 2) start = 1'b0;
    end while (!done && gap < 12);
`ifdef TV80_ALU16_BACK2BACK_EN
    check("b2b_gap", gap, 32'd3);
`else
    check("b2b_gap", gap, 32'd4);
`endif
    check("b2b_res", {16'b0, result}, 32'hFFFF);
    check("b2b_f", {24'b0, f_out}, 32'hBB);

    // reset while the high byte is being computed
    @(negedge clk);
    op = 2'b00; opa = 16'h00FF; opb = 16'h0001; f_in = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rst_mid_busy_pre", {31'b0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_done", {31'b0, done}, 32'd0);
    check("rst_mid_res", {16'b0, result}, 32'd0);
    check("rst_mid_f", {24'b0, f_out}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("rst_mid_nodone", cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
